// File: rtl/demultiplexor_4_20_16x20.sv
// Write-side demultiplexor: one addressed write per cycle into sixteen holding
// registers, all presented in parallel, with write acknowledge and written mask.
module demultiplexor_4_20_16x20 #(
    parameter int               WIDTH       = 20,
    parameter int               ADDR_W      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    output logic [WIDTH-1:0]      out0,
    output logic [WIDTH-1:0]      out1,
    output logic [WIDTH-1:0]      out2,
    output logic [WIDTH-1:0]      out3,
    output logic [WIDTH-1:0]      out4,
    output logic [WIDTH-1:0]      out5,
    output logic [WIDTH-1:0]      out6,
    output logic [WIDTH-1:0]      out7,
    output logic [WIDTH-1:0]      out8,
    output logic [WIDTH-1:0]      out9,
    output logic [WIDTH-1:0]      out10,
    output logic [WIDTH-1:0]      out11,
    output logic [WIDTH-1:0]      out12,
    output logic [WIDTH-1:0]      out13,
    output logic [WIDTH-1:0]      out14,
    output logic [WIDTH-1:0]      out15,
    output logic                  wr_ack,
    output logic [ADDR_W-1:0]     wr_addr_q,
    output logic [(1<<ADDR_W)-1:0] written
);

    localparam int NREG = 1 << ADDR_W;

    // Handshake: we acts as a valid with the sink always ready; every cycle with
    // we=1 (and rst=0) is accepted and echoed by wr_ack one cycle later.
    logic [WIDTH-1:0]  regs_q [NREG];
    logic [WIDTH-1:0]  regs_d [NREG];
    logic [NREG-1:0]   sel;
    logic [NREG-1:0]   written_q, written_d;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        sel = '0;
        if (we) begin
            sel[addr] = 1'b1;
        end
        for (int k = 0; k < NREG; k++) begin
            regs_d[k] = sel[k] ? in : regs_q[k];
        end
        written_d = written_q | sel;
        ack_d     = we;
        addr_d    = we ? addr : addr_q;
    end

    // Reset wins over a concurrent write; the dropped write leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
            written_q <= '0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= regs_d[k];
            end
            written_q <= written_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
        end
    end

    assign out0      = regs_q[0];
    assign out1      = regs_q[1];
    assign out2      = regs_q[2];
    assign out3      = regs_q[3];
    assign out4      = regs_q[4];
    assign out5      = regs_q[5];
    assign out6      = regs_q[6];
    assign out7      = regs_q[7];
    assign out8      = regs_q[8];
    assign out9      = regs_q[9];
    assign out10     = regs_q[10];
    assign out11     = regs_q[11];
    assign out12     = regs_q[12];
    assign out13     = regs_q[13];
    assign out14     = regs_q[14];
    assign out15     = regs_q[15];
    assign wr_ack    = ack_q;
    assign wr_addr_q = addr_q;
    assign written   = written_q;

endmodule

// File: tb/tb_demultiplexor_4_20_16x20.sv
// Bench for demultiplexor_4_20_16x20: directed writes with a queued scoreboard
// checked on every wr_ack, plus full-state checks and a random round trip.
module tb_demultiplexor_4_20_16x20;

    logic        clk;
    logic        rst;
    logic [19:0] in;
    logic [3:0]  addr;
    logic        we;
    logic [19:0] outs [16];
    logic        wr_ack;
    logic [3:0]  wr_addr_q;
    logic [15:0] written;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    // Scoreboard entry: {addr[39:36], data[35:16], written mask after[15:0]}
    logic [39:0] exp_q [$];
    logic [19:0] model [16];
    logic [15:0] wmask;

    demultiplexor_4_20_16x20 dut (
        .clk(clk), .rst(rst), .in(in), .addr(addr), .we(we),
        .out0(outs[0]),   .out1(outs[1]),   .out2(outs[2]),   .out3(outs[3]),
        .out4(outs[4]),   .out5(outs[5]),   .out6(outs[6]),   .out7(outs[7]),
        .out8(outs[8]),   .out9(outs[9]),   .out10(outs[10]), .out11(outs[11]),
        .out12(outs[12]), .out13(outs[13]), .out14(outs[14]), .out15(outs[15]),
        .wr_ack(wr_ack), .wr_addr_q(wr_addr_q), .written(written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every acknowledged write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (wr_ack === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_ack: got ack addr %h expected no ack", wr_addr_q);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("sb_addr", {28'h0, wr_addr_q}, {28'h0, e[39:36]});
                chk("sb_data", {12'h0, outs[e[39:36]]}, {12'h0, e[35:16]});
                chk("sb_written", {16'h0, written}, {16'h0, e[15:0]});
            end
        end
    end

    // Drivers start just after a negedge and return on the next one.
    task automatic do_write(input logic [3:0] a, input logic [19:0] d);
        rst = 1'b0; we = 1'b1; addr = a; in = d;
        model[a] = d;
        wmask[a] = 1'b1;
        exp_q.push_back({a, d, wmask});
        @(negedge clk);
    endtask

    task automatic do_idle();
        rst = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] a, input logic [19:0] d, input int cycles);
        rst = 1'b1; we = 1'b1; addr = a; in = d;
        for (int k = 0; k < 16; k++) model[k] = 20'h0;
        wmask = 16'h0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_all(input string name);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_out%0d", name, k), {12'h0, outs[k]}, {12'h0, model[k]});
        end
        chk({name, "_written"}, {16'h0, written}, {16'h0, wmask});
    endtask

    function automatic logic [19:0] rd_mux(input logic [3:0] a);
        return outs[a];
    endfunction

    initial begin
        int ack0;
        logic [3:0]  ra;
        logic [19:0] rd;
        rst = 1'b1; we = 1'b1; addr = 4'h3; in = 20'hABCDE;
        wmask = 16'h0;
        for (int k = 0; k < 16; k++) model[k] = 20'h0;
        @(negedge clk);

        // Reset held two cycles with a write pending
        do_reset(4'h3, 20'hABCDE, 2);
        check_all("reset");
        chk("reset_ack", {31'h0, wr_ack}, 32'h0);
        chk("reset_addr", {28'h0, wr_addr_q}, 32'h0);

        // Single write; no bypass before the edge
        rst = 1'b0; we = 1'b1; addr = 4'h5; in = 20'h12345;
        #1 chk("no_bypass", {12'h0, outs[5]}, 32'h0);
        do_write(4'h5, 20'h12345);
        chk("single_out5", {12'h0, outs[5]}, 32'h12345);
        chk("single_written", {16'h0, written}, 32'h0020);
        chk("single_ack", {31'h0, wr_ack}, 32'h1);
        chk("single_addr", {28'h0, wr_addr_q}, 32'h5);
        check_all("single");
        do_idle();
        chk("idle_ack", {31'h0, wr_ack}, 32'h0);
        chk("idle_addr_hold", {28'h0, wr_addr_q}, 32'h5);
        chk("idle_out5", {12'h0, outs[5]}, 32'h12345);

        // Sweep all addresses back to back
        ack0 = ack_cnt;
        for (int k = 0; k < 16; k++) begin
            do_write(4'(k), 20'hF0000 | 20'(k));
        end
        do_idle();
        chk("sweep_ack_cycles", ack_cnt - ack0, 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("sweep_out%0d", k), {12'h0, outs[k]}, {12'h0, 20'hF0000 | 20'(k)});
        end
        chk("sweep_written", {16'h0, written}, 32'hFFFF);

        // Overwrite and isolation
        do_write(4'hF, 20'hFFFFF);
        do_write(4'hF, 20'h00001);
        chk("ovw_out15", {12'h0, outs[15]}, 32'h00001);
        chk("ovw_out14", {12'h0, outs[14]}, 32'hF000E);
        chk("ovw_out0", {12'h0, outs[0]}, 32'hF0000);
        chk("ovw_written15", {31'h0, written[15]}, 32'h1);
        do_idle();

        // Reset priority mid-operation
        do_reset(4'h2, 20'h55555, 1);
        check_all("rstprio");
        chk("rstprio_ack", {31'h0, wr_ack}, 32'h0);
        do_write(4'h2, 20'h55555);
        chk("post_rst_out2", {12'h0, outs[2]}, 32'h55555);
        chk("post_rst_written", {16'h0, written}, 32'h0004);
        check_all("post_rst");
        do_idle();

        // Round trip through a read mux of the parallel outputs
        do_reset(4'h0, 20'h0, 1);
        void'($urandom(74651));
        for (int i = 0; i < 10; i++) begin
            do_write(4'($urandom_range(15, 0)), 20'($urandom_range(20'hFFFFF, 0)));
        end
        do_idle();
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(15, 0));
            rd = rd_mux(ra);
            chk($sformatf("rt_addr%0h", ra), {12'h0, rd}, {12'h0, wmask[ra] ? model[ra] : 20'h0});
        end
        check_all("rt_final");

        do_idle();
        chk("sb_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demultiplexor_4_20_16x20.md
# demultiplexor_4_20_16x20

Write-side counterpart of the 16-way, 20-bit read multiplexor in the URCPU datapath. It accepts one 20-bit word plus a 4-bit address per cycle and decodes the address to a single target. The word is latched into that one of sixteen 20-bit holding registers. All sixteen registers are presented in parallel on `out0`..`out15`, which drive the read multiplexor's `in0`..`in15`. The block also reports a write acknowledge and a per-register "written since reset" mask.

## Interface
Parameters:
- `WIDTH`, 20, data width of every word
- `ADDR_W`, 4, address width; register count is 2**ADDR_W = 16
- `RESET_VALUE`, 20'h00000, value loaded into every register on reset

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in`  input  20  write data
- `addr`  input  4  target register index 0..15
- `we`  input  1  write enable; sampled on rising `clk`
- `out0`..`out15`  output  20 each  current content of register 0..15
- `wr_ack`  output  1  one-cycle pulse, the cycle after an accepted write
- `wr_addr_q`  output  4  address of the most recent accepted write
- `written`  output  16  bit k set once register k has been written since reset

## Operation
- Reset (`rst`=1 at edge): every `outk` becomes RESET_VALUE, `written`=16'h0000, `wr_ack`=0, `wr_addr_q`=4'h0.
- `rst` has priority over `we` in the same cycle. The write is dropped and does not set any `written` bit.
- Accepted write (`rst`=0, `we`=1): register `addr` takes `in`, `written[addr]` is set, `wr_ack`=1 and `wr_addr_q`=`addr` on the following cycle.
- Only the addressed register changes. The other fifteen hold their value bit-exact.
- `we`=0: all registers and `written` hold. `wr_ack`=0 and `wr_addr_q` holds.
- Address decode is full: all 16 codes are valid, with no reserved or read-only register.
- `in` is stored unmodified, with no truncation, extension or arithmetic.
- Back-to-back writes to the same address: each write takes effect at its own edge, so the last one wins. `wr_ack` stays high for every consecutive write cycle.
- Back-to-back writes to different addresses: each one updates only its own register.
- Once set, a `written` bit stays set until reset. Rewriting a register does not change its bit.
- Reset asserted mid-sequence: the state clears at that edge. Writes in the following cycle behave as after a fresh reset.
- Inputs `in`, `addr` and `we` with X/Z during reset are ignored.

## Timing
- Write latency is 1 cycle: the value presented at edge N is visible on `outk` immediately after edge N.
- There is no combinational path from `in`, `addr` or `we` to any output. All outputs are registered.
- There is no read bypass. In the write cycle itself, `outk` still shows the old value until the edge.
- `wr_ack` and `wr_addr_q` update at the same edge as the register write.
- Throughput is one write per cycle, with no stall or back-pressure.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `we`=1, `addr`=4'h3, `in`=20'hABCDE. Required: all `outk`=20'h00000, `written`=16'h0000, `wr_ack`=0.
- Single write: `we`=1, `addr`=4'h5, `in`=20'h12345 for one cycle. Required after the edge: `out5`=20'h12345, all other outputs 0, `written`=16'h0020, `wr_ack`=1, `wr_addr_q`=4'h5. Next cycle with `we`=0: `wr_ack`=0 and the values hold.
- Sweep: write `in`=20'hF0000 | k to `addr`=k for k=0..15 on consecutive cycles. Required: `outk`=20'hF0000 | k for every k, `written`=16'hFFFF, `wr_ack` high for 16 cycles.
- Overwrite and isolation: write 20'hFFFFF then 20'h00001 to `addr`=4'hF on back-to-back cycles. Required: `out15`=20'h00001, `out14`=`out0` unchanged, `written[15]`=1.
- Reset priority mid-operation: after the sweep, assert `rst`=1 together with `we`=1, `addr`=4'h2, `in`=20'h55555. Required: all outputs 0 and `written`=16'h0000. Next cycle write 20'h55555 to `addr`=4'h2: `out2`=20'h55555, `written`=16'h0004.
- Round-trip: drive `out0`..`out15` into `multiplexor_16x20_4_20`. Write 10 random words to random addresses using seed 74651, then read back with random read `addr`. Required: the mux output equals the last word written to that address, or 0 if that address was never written.
